// File: rtl/phys_free_list_if.sv
// Bundle of the rename/commit-facing signals of the physical free list.
//   master : the pipeline side. It drives the alloc requests, commit count, frees and flush,
//            and it reads back the tags, the ready flag, the count and the error flags.
//   slave  : the free list itself.
// clk_en travels with the bundle because it gates every transaction on it.
interface phys_free_list_if #(
  parameter int unsigned PHYS_COUNT      = 64,
  parameter int unsigned PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT),
  parameter int unsigned ALLOC_PORTS     = 4,
  parameter int unsigned FREE_PORTS      = 4,
  parameter int unsigned CNT_WIDTH       = $clog2(PHYS_COUNT + 1)
);
  localparam int unsigned CommitWidth = $clog2(ALLOC_PORTS + 1);

  logic                                         clk_en;
  logic [ALLOC_PORTS-1:0]                       alloc_req;
  logic                                         alloc_ready;
  logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  alloc_tag;
  logic [CommitWidth-1:0]                       commit_cnt;
  logic [FREE_PORTS-1:0]                        free_en;
  logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]   free_tag;
  logic                                         flush;
  logic [CNT_WIDTH-1:0]                         free_count;
  logic                                         err_overflow;
  logic                                         err_underflow;

  modport master (
    output clk_en, alloc_req, commit_cnt, free_en, free_tag, flush,
    input  alloc_ready, alloc_tag, free_count, err_overflow, err_underflow
  );

  modport slave (
    input  clk_en, alloc_req, commit_cnt, free_en, free_tag, flush,
    output alloc_ready, alloc_tag, free_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/phys_free_list.sv
// Physical register free list. It is a circular ring of free tags with three pointers:
//   head  : speculative alloc point. Rename takes tags from here.
//   chead : committed alloc point. head rolls back to it on flush.
//   tail  : insertion point for tags released by commit.
// Ports:
//   clk, sync_rst_n : clock and asynchronous active-low reset.
//   fl (slave)      : clk_en, alloc_req/alloc_ready/alloc_tag, commit_cnt, free_en/free_tag,
//                     flush, free_count, err_overflow, err_underflow.
// alloc_tag is show-ahead and combinational from alloc_req. All other outputs are registers.
module phys_free_list #(
  parameter int unsigned PHYS_COUNT      = 64,
  parameter int unsigned ARCH_COUNT      = 32,
  parameter int unsigned PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT),
  parameter int unsigned ALLOC_PORTS     = 4,
  parameter int unsigned FREE_PORTS      = 4,
  parameter int unsigned CNT_WIDTH       = $clog2(PHYS_COUNT + 1)
) (
  input logic             clk,
  input logic             sync_rst_n,
  phys_free_list_if.slave fl
);
  localparam int unsigned InitFree = PHYS_COUNT - ARCH_COUNT;

  typedef logic [PHYS_ADDR_WIDTH-1:0] ptr_t;

  ptr_t                  head_q, head_d;
  ptr_t                  chead_q, chead_d;
  ptr_t                  tail_q, tail_d;
  ptr_t [PHYS_COUNT-1:0] ring_q, ring_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;

  ptr_t alloc_rank [ALLOC_PORTS];
  ptr_t alloc_total;
  ptr_t free_rank  [FREE_PORTS];
  ptr_t free_total;
  ptr_t in_flight;
  ptr_t occupied;
  ptr_t count_diff;

  // Prefix popcounts: a slot's rank is the number of set bits below it.
  always_comb begin
    alloc_total = '0;
    for (int unsigned i = 0; i < ALLOC_PORTS; i++) begin
      alloc_rank[i] = alloc_total;
      alloc_total   = alloc_total + ptr_t'(fl.alloc_req[i]);
    end
  end

  always_comb begin
    free_total = '0;
    for (int unsigned j = 0; j < FREE_PORTS; j++) begin
      free_rank[j] = free_total;
      free_total   = free_total + ptr_t'(fl.free_en[j]);
    end
  end

  // Every slot shows the tag at its rank, even when it is not requesting.
  always_comb begin
    for (int unsigned i = 0; i < ALLOC_PORTS; i++) begin
      fl.alloc_tag[i] = ring_q[ptr_t'(head_q + alloc_rank[i])];
    end
  end

  always_comb begin
    head_d    = head_q;
    chead_d   = chead_q;
    tail_d    = tail_q;
    ring_d    = ring_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;

    // Allocations not yet retired, and tags outside the ring's free window.
    in_flight = head_q - chead_q;
    occupied  = tail_q - chead_q;

    if (fl.clk_en) begin
      if (ptr_t'(fl.commit_cnt) > in_flight) begin
        err_unf_d = 1'b1;
      end else begin
        chead_d = chead_q + ptr_t'(fl.commit_cnt);
      end

      // Accepting more frees than the free window can hold would overwrite live tags.
      if (free_total > ptr_t'(InitFree) - occupied) begin
        err_ovf_d = 1'b1;
      end else begin
        for (int unsigned j = 0; j < FREE_PORTS; j++) begin
          if (fl.free_en[j]) begin
            ring_d[ptr_t'(tail_q + free_rank[j])] = fl.free_tag[j];
          end
        end
        tail_d = tail_q + free_total;
      end

      // The rollback target includes any commit made in the same cycle.
      if (fl.flush) begin
        head_d = chead_d;
      end else if (ready_q && (|fl.alloc_req)) begin
        head_d = head_q + alloc_total;
      end
    end

    count_diff = tail_d - head_d;
    count_d    = CNT_WIDTH'(count_diff);
    ready_d    = (count_d >= CNT_WIDTH'(ALLOC_PORTS));
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      head_q    <= '0;
      chead_q   <= '0;
      tail_q    <= ptr_t'(InitFree);
      count_q   <= CNT_WIDTH'(InitFree);
      ready_q   <= (InitFree >= ALLOC_PORTS);
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      for (int unsigned i = 0; i < PHYS_COUNT; i++) begin
        ring_q[i] <= (i < InitFree) ? ptr_t'(ARCH_COUNT + i) : '0;
      end
    end else begin
      head_q    <= head_d;
      chead_q   <= chead_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      ring_q    <= ring_d;
    end
  end

  assign fl.alloc_ready   = ready_q;
  assign fl.free_count    = count_q;
  assign fl.err_overflow  = err_ovf_q;
  assign fl.err_underflow = err_unf_q;
endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;
  localparam int P  = 64;
  localparam int A  = 32;
  localparam int AP = 4;
  localparam int FP = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  phys_free_list_if #(.PHYS_COUNT(P), .ALLOC_PORTS(AP), .FREE_PORTS(FP)) bus ();

  phys_free_list #(.PHYS_COUNT(P), .ARCH_COUNT(A), .ALLOC_PORTS(AP), .FREE_PORTS(FP)) dut (
    .clk       (clk),
    .sync_rst_n(rst_n),
    .fl        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain array of tags and integer pointers taken modulo P.
  int m_ring [P];
  int m_head, m_chead, m_tail;
  bit m_eo, m_eu;

  function automatic int modp(input int x);
    return ((x % P) + P) % P;
  endfunction

  function automatic int m_count();
    return modp(m_tail - m_head);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < P; i++) m_ring[i] = (i < P - A) ? A + i : 0;
    m_head = 0; m_chead = 0; m_tail = P - A; m_eo = 0; m_eu = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (bus.clk_en) begin
      int na, nf, k, new_chead;
      bit rdy;
      rdy = (m_count() >= AP);
      na  = $countones(bus.alloc_req);
      nf  = $countones(bus.free_en);
      new_chead = m_chead;
      if (int'(bus.commit_cnt) > modp(m_head - m_chead)) m_eu = 1;
      else new_chead = modp(m_chead + int'(bus.commit_cnt));
      if (nf > (P - A) - modp(m_tail - m_chead)) begin
        m_eo = 1;
      end else begin
        k = 0;
        for (int j = 0; j < FP; j++) begin
          if (bus.free_en[j]) begin
            m_ring[modp(m_tail + k)] = int'(bus.free_tag[j]);
            k++;
          end
        end
        m_tail = modp(m_tail + nf);
      end
      if (bus.flush) m_head = new_chead;
      else if (rdy && na > 0) m_head = modp(m_head + na);
      m_chead = new_chead;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int rank;
      chk("free_count", 32'(bus.free_count), m_count());
      chk("alloc_ready", 32'(bus.alloc_ready), 32'(m_count() >= AP));
      chk("err_overflow", 32'(bus.err_overflow), 32'(m_eo));
      chk("err_underflow", 32'(bus.err_underflow), 32'(m_eu));
      rank = 0;
      for (int i = 0; i < AP; i++) begin
        chk($sformatf("alloc_tag%0d", i), 32'(bus.alloc_tag[i]), m_ring[modp(m_head + rank)]);
        if (bus.alloc_req[i]) rank++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] req, input int commit, input logic [3:0] fen,
                        input logic [23:0] ftags, input logic fl);
    bus.clk_en     = 1'b1;
    bus.alloc_req  = req;
    bus.commit_cnt = 3'(commit);
    bus.free_en    = fen;
    bus.free_tag   = ftags;
    bus.flush      = fl;
    #1;
  endtask

  task automatic idle();
    set_in(4'b0000, 0, 4'b0000, 24'd0, 1'b0);
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst free_count", 32'(bus.free_count), 32);
    chk("rst alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst errs", {30'd0, bus.err_overflow, bus.err_underflow}, 0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    #12;

    // 1: four tags from reset
    reset_dut();
    set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
    chk("t1 tags", {8'd0, 6'd0, bus.alloc_tag[3], bus.alloc_tag[2], bus.alloc_tag[1],
        bus.alloc_tag[0]}, {8'd0, 6'd0, 6'd35, 6'd34, 6'd33, 6'd32});
    tick();
    idle();
    chk("t1 count", 32'(bus.free_count), 28);

    // 2: sparse request pattern
    reset_dut();
    set_in(4'b1010, 0, 4'b0000, 24'd0, 1'b0);
    chk("t2 tag1", 32'(bus.alloc_tag[1]), 32);
    chk("t2 tag3", 32'(bus.alloc_tag[3]), 33);
    tick();
    set_in(4'b0001, 0, 4'b0000, 24'd0, 1'b0);
    chk("t2 next tag0", 32'(bus.alloc_tag[0]), 34);
    tick();

    // 3: drain to empty, then stall
    reset_dut();
    for (int c = 0; c < 7; c++) begin
      set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
      tick();
    end
    idle();
    chk("t3 count7", 32'(bus.free_count), 4);
    chk("t3 ready7", 32'(bus.alloc_ready), 1);
    set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
    tick();
    idle();
    chk("t3 count8", 32'(bus.free_count), 0);
    chk("t3 ready8", 32'(bus.alloc_ready), 0);
    set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
    tick();
    idle();
    chk("t3 stall count", 32'(bus.free_count), 0);
    chk("t3 stall err", {30'd0, bus.err_overflow, bus.err_underflow}, 0);

    // 4: alloc and free together (after a commit opens room in the free window)
    reset_dut();
    set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
    tick();
    set_in(4'b0000, 4, 4'b0000, 24'd0, 1'b0);
    tick();
    set_in(4'b1111, 0, 4'b0011, {6'd0, 6'd0, 6'd6, 6'd5}, 1'b0);
    tick();
    idle();
    chk("t4 count", 32'(bus.free_count), 26);
    chk("t4 ovf", 32'(bus.err_overflow), 0);
    for (int c = 0; c < 6; c++) begin
      set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
      tick();
    end
    set_in(4'b0011, 0, 4'b0000, 24'd0, 1'b0);
    chk("t4 tag5", 32'(bus.alloc_tag[0]), 5);
    chk("t4 tag6", 32'(bus.alloc_tag[1]), 6);
    tick();

    // 5: flush with a same-cycle commit
    reset_dut();
    set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
    tick();
    set_in(4'b1111, 0, 4'b0000, 24'd0, 1'b0);
    tick();
    set_in(4'b0000, 3, 4'b0000, 24'd0, 1'b0);
    tick();
    set_in(4'b1111, 1, 4'b0000, 24'd0, 1'b1);
    tick();
    set_in(4'b0001, 0, 4'b0000, 24'd0, 1'b0);
    chk("t5 tag", 32'(bus.alloc_tag[0]), 36);
    chk("t5 count", 32'(bus.free_count), 28);
    tick();

    // 6: overflow then underflow, both sticky
    reset_dut();
    set_in(4'b0000, 0, 4'b0001, 24'd7, 1'b0);
    tick();
    idle();
    chk("t6 ovf", 32'(bus.err_overflow), 1);
    chk("t6 count", 32'(bus.free_count), 32);
    tick();
    chk("t6 ovf sticky", 32'(bus.err_overflow), 1);
    set_in(4'b0000, 1, 4'b0000, 24'd0, 1'b0);
    tick();
    idle();
    chk("t6 unf", 32'(bus.err_underflow), 1);
    chk("t6 ovf still", 32'(bus.err_overflow), 1);

    // Random phase, mostly-legal traffic with occasional errors and resets
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      int inflight, room, cmax;
      logic [3:0] fen;
      logic [23:0] ftags;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      inflight = modp(m_head - m_chead);
      room     = (P - A) - modp(m_tail - m_chead);
      cmax     = (inflight < AP) ? inflight : AP;
      bus.clk_en     = ($urandom_range(0, 9) != 0);
      bus.alloc_req  = 4'($urandom);
      bus.flush      = ($urandom_range(0, 15) == 0);
      bus.commit_cnt = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(0, AP))
                                                     : 3'($urandom_range(0, cmax));
      fen   = 4'($urandom);
      ftags = 24'($urandom);
      if ($countones(fen) > room && $urandom_range(0, 31) != 0) fen = 4'b0000;
      bus.free_en  = fen;
      bus.free_tag = ftags;
      tick();
    end

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
